// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared widths, address-width helper and typedefs for the register file
package reg_file_pkg;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;

    typedef logic [DATA_W-1:0]       data_t;
    typedef logic [addr_w(NREGS)-1:0] addr_t;
    typedef logic [NREGS-1:0]        busy_vec_t;

endpackage

// File: rtl/reg_file_bank.sv
// reg_file_bank: register storage with multi-port writes; the highest-index port wins an address clash
module reg_file_bank
    import reg_file_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_W,
    parameter  int NUM_REGS   = NREGS,
    parameter  int NUM_WRITE  = 2,
    parameter  int ZERO_REG   = 1,
    localparam int ADDR_W     = addr_w(NUM_REGS)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_WRITE-1:0]                  we_i,
    input  logic [NUM_WRITE-1:0][ADDR_W-1:0]      waddr_i,
    input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0]  wdata_i,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   mem_o
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < NUM_WRITE; p++)
            if (we_i[p]) mem_d[waddr_i[p]] = wdata_i[p];
        if (ZERO_REG != 0) mem_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) mem_q <= '0;
        else        mem_q <= mem_d;

    assign mem_o = mem_q;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with per-register busy scoreboard and claim handshake
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_REGS   = 32,
    parameter  int NUM_READ   = 2,
    parameter  int NUM_WRITE  = 2,
    parameter  int BYPASS     = 1,
    parameter  int ZERO_REG   = 1,
    localparam int ADDR_W     = addr_w(NUM_REGS)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_READ-1:0][ADDR_W-1:0]       i_read_addr,
    output logic [NUM_READ-1:0][DATA_WIDTH-1:0]   o_read_data,
    output logic [NUM_READ-1:0]                   o_read_busy,
    input  logic [NUM_WRITE-1:0]                  i_write_enable,
    input  logic [NUM_WRITE-1:0][ADDR_W-1:0]      i_write_addr,
    input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0]  i_write_data,
    input  logic                                  i_claim_valid,
    input  logic [ADDR_W-1:0]                     i_claim_addr,
    output logic                                  o_claim_ready,
    output logic [NUM_REGS-1:0]                   o_busy_vec
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem;
    logic [NUM_REGS-1:0]                 busy_q, busy_d, wr_hit;

    reg_file_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .NUM_WRITE (NUM_WRITE),
        .ZERO_REG  (ZERO_REG)
    ) u_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (i_write_enable),
        .waddr_i(i_write_addr),
        .wdata_i(i_write_data),
        .mem_o  (mem)
    );

    // A write releases its register; a claim on the same edge re-sets it, so the claim wins.
    always_comb begin
        wr_hit = '0;
        for (int p = 0; p < NUM_WRITE; p++)
            if (i_write_enable[p]) wr_hit[i_write_addr[p]] = 1'b1;
        o_claim_ready = i_claim_valid & (~busy_q[i_claim_addr] | wr_hit[i_claim_addr]);
        busy_d = busy_q & ~wr_hit;
        if (o_claim_ready) busy_d[i_claim_addr] = 1'b1;
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;

    assign o_busy_vec = busy_q;

    always_comb begin
        for (int r = 0; r < NUM_READ; r++) begin
            o_read_data[r] = mem[i_read_addr[r]];
            o_read_busy[r] = busy_q[i_read_addr[r]];
            if (BYPASS != 0)
                for (int p = 0; p < NUM_WRITE; p++)
                    if (i_write_enable[p] && i_write_addr[p] == i_read_addr[r]) begin
                        o_read_data[r] = i_write_data[p];
                        o_read_busy[r] = 1'b0;
                    end
            if (ZERO_REG != 0 && i_read_addr[r] == '0) begin
                o_read_data[r] = '0;
                o_read_busy[r] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed and random checks of two reg_file_sb instances (bypass on/off) against an array model
module tb_reg_file_sb;
    import reg_file_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0][4:0]  raddr;
    logic [1:0][31:0] rdata1, rdata0;
    logic [1:0]       rbusy1, rbusy0;
    logic [1:0]       we;
    logic [1:0][4:0]  waddr;
    logic [1:0][31:0] wdata;
    logic             cv;
    logic [4:0]       ca;
    logic             cr1, cr0;
    logic [31:0]      bv1, bv0;

    int errors = 0;
    int checks = 0;

    data_t regs [NREGS];
    bit    busy_m [NREGS];

    always #5 clk = ~clk;

    reg_file_sb #(.BYPASS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_read_addr(raddr), .o_read_data(rdata1), .o_read_busy(rbusy1),
        .i_write_enable(we), .i_write_addr(waddr), .i_write_data(wdata),
        .i_claim_valid(cv), .i_claim_addr(ca), .o_claim_ready(cr1), .o_busy_vec(bv1)
    );

    reg_file_sb #(.BYPASS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_read_addr(raddr), .o_read_data(rdata0), .o_read_busy(rbusy0),
        .i_write_enable(we), .i_write_addr(waddr), .i_write_data(wdata),
        .i_claim_valid(cv), .i_claim_addr(ca), .o_claim_ready(cr0), .o_busy_vec(bv0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) begin
            regs[i] = '0;
            busy_m[i] = 1'b0;
        end
    endfunction

    function automatic void exp_read(input bit byp, input logic [4:0] a, output logic [31:0] d, output logic b);
        d = regs[a];
        b = busy_m[a];
        if (byp)
            for (int p = 0; p < 2; p++)
                if (we[p] && waddr[p] == a) begin
                    d = wdata[p];
                    b = 1'b0;
                end
        if (a == 0) begin
            d = '0;
            b = 1'b0;
        end
    endfunction

    task automatic idle();
        we = '0;
        cv = 1'b0;
    endtask

    // Compare every output against the model, then clock and advance the model.
    task automatic step();
        logic [31:0] ed;
        logic        eb;
        logic [31:0] ebv;
        bit          hit;
        bit          rdy;
        #1;
        for (int r = 0; r < 2; r++) begin
            exp_read(1'b1, raddr[r], ed, eb);
            check($sformatf("rdata%0d_byp1", r), rdata1[r], ed);
            check($sformatf("rbusy%0d_byp1", r), {31'b0, rbusy1[r]}, {31'b0, eb});
            exp_read(1'b0, raddr[r], ed, eb);
            check($sformatf("rdata%0d_byp0", r), rdata0[r], ed);
            check($sformatf("rbusy%0d_byp0", r), {31'b0, rbusy0[r]}, {31'b0, eb});
        end
        hit = 1'b0;
        for (int p = 0; p < 2; p++)
            if (we[p] && waddr[p] == ca) hit = 1'b1;
        rdy = cv && (!busy_m[ca] || hit);
        check("claim_ready_byp1", {31'b0, cr1}, {31'b0, rdy});
        check("claim_ready_byp0", {31'b0, cr0}, {31'b0, rdy});
        for (int i = 0; i < NREGS; i++) ebv[i] = busy_m[i];
        check("busy_vec_byp1", bv1, ebv);
        check("busy_vec_byp0", bv0, ebv);
        @(posedge clk);
        for (int p = 0; p < 2; p++)
            if (we[p] && waddr[p] != 0) begin
                regs[waddr[p]] = wdata[p];
                busy_m[waddr[p]] = 1'b0;
            end
        if (rdy && ca != 0) busy_m[ca] = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        raddr = '0;
        waddr = '0;
        wdata = '0;
        ca = '0;
        idle();
        cv = 1'b1;
        model_reset();
        #1;
        check("reset_rdata", rdata1[0], 32'h0);
        check("reset_busy_vec", bv1, 32'h0);
        check("reset_claim_ready", {31'b0, cr1}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cv = 1'b0;

        // preload, then asynchronous reset mid-cycle
        we = 2'b01; waddr[0] = 5'd1; wdata[0] = 32'hA1; cv = 1'b1; ca = 5'd4;
        step();
        idle(); raddr[0] = 5'd1; raddr[1] = 5'd4;
        step();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rdata0", rdata1[0], 32'h0);
        check("midrst_rdata0_byp0", rdata0[0], 32'h0);
        check("midrst_rbusy1", {31'b0, rbusy1[1]}, 32'h0);
        check("midrst_busy_vec", bv1, 32'h0);
        model_reset();
        #1 rst_n = 1'b1;
        @(negedge clk);

        // write-port priority
        we = 2'b11; waddr[0] = 5'd5; waddr[1] = 5'd5; wdata[0] = 32'h11; wdata[1] = 32'h22; raddr[0] = 5'd5;
        #1 check("prio_bypass", rdata1[0], 32'h22);
        step();
        idle();
        #1 check("prio_stored", rdata0[0], 32'h22);
        step();

        // bypass vs. no bypass
        we = 2'b01; waddr[0] = 5'd7; wdata[0] = 32'h1234;
        step();
        waddr[0] = 5'd7; wdata[0] = 32'hDEAD; raddr[0] = 5'd7;
        #1;
        check("bypass_on", rdata1[0], 32'hDEAD);
        check("bypass_off_old", rdata0[0], 32'h1234);
        step();
        idle();
        #1 check("bypass_off_new", rdata0[0], 32'hDEAD);
        step();

        // scoreboard
        cv = 1'b1; ca = 5'd3; raddr[1] = 5'd3;
        #1 check("claim_r3_ready", {31'b0, cr1}, 32'h1);
        step();
        #1;
        check("claim_r3_busy", {31'b0, bv1[3]}, 32'h1);
        check("claim_r3_again", {31'b0, cr1}, 32'h0);
        check("claim_r3_rbusy", {31'b0, rbusy0[1]}, 32'h1);
        step();
        cv = 1'b0; we = 2'b01; waddr[0] = 5'd3; wdata[0] = 32'h5;
        #1 check("release_r3_bypass_busy", {31'b0, rbusy1[1]}, 32'h0);
        step();
        idle();
        #1;
        check("release_r3_busy", {31'b0, bv1[3]}, 32'h0);
        check("release_r3_data", rdata0[1], 32'h5);
        step();

        // write + claim collision
        cv = 1'b1; ca = 5'd9;
        step();
        we = 2'b01; waddr[0] = 5'd9; wdata[0] = 32'h9;
        #1 check("collide_ready", {31'b0, cr1}, 32'h1);
        step();
        idle(); raddr[0] = 5'd9;
        #1;
        check("collide_data", rdata0[0], 32'h9);
        check("collide_busy", {31'b0, bv1[9]}, 32'h1);
        step();

        // zero register
        we = 2'b01; waddr[0] = 5'd0; wdata[0] = 32'hFFFF; cv = 1'b1; ca = 5'd0; raddr = '0;
        #1;
        check("zero_rdata_byp", rdata1[0], 32'h0);
        check("zero_rbusy", {31'b0, rbusy1[0]}, 32'h0);
        check("zero_claim_ready", {31'b0, cr1}, 32'h1);
        step();
        idle();
        #1;
        check("zero_rdata", rdata0[0], 32'h0);
        check("zero_busy_vec", {31'b0, bv1[0]}, 32'h0);
        step();

        // random traffic on a narrowed address range to force collisions
        for (int n = 0; n < 400; n++) begin
            we = 2'($urandom);
            for (int p = 0; p < 2; p++) begin
                waddr[p] = 5'($urandom_range(0, 11));
                wdata[p] = $urandom;
            end
            for (int r = 0; r < 2; r++) raddr[r] = 5'($urandom_range(0, 11));
            cv = 1'($urandom);
            ca = 5'($urandom_range(0, 11));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
